wb_scr_mem_arbiter: RTL and testbench
=====================================

Name: wb_scr_mem_arbiter

Overview:
- Two-port arbiter that shares the single SCR1 Wishbone master adapter between the core's instruction-fetch port (imem) and data port (dmem).
- Arbitrates round-robin and latches the winning request. Presents the request on the adapter's valid/ready request interface, then returns read data and a one-cycle ready pulse to the winning port.
- Sits between the SCR1 memory-interface bridges and the Wishbone master adapter, in the wb_clk_i domain.

Parameters:
- AWIDTH, 32, address width of both ports and the downstream request.
- DWIDTH, 32, data width; fixed at 32, so byte strobes are 4 bits.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- imem_valid_i  in  1  instruction-fetch request; held until imem_ready_o.
- imem_addr_i  in  AWIDTH  fetch address; stable while imem_valid_i is high.
- imem_ready_o  out  1  one-cycle completion pulse.
- imem_rdata_o  out  DWIDTH  fetch data; valid while imem_ready_o is high.
- dmem_valid_i  in  1  data request; held until dmem_ready_o.
- dmem_addr_i  in  AWIDTH  data address.
- dmem_wdata_i  in  DWIDTH  write data.
- dmem_wstrb_i  in  4  byte strobes; 0 means read, non-zero means write.
- dmem_ready_o  out  1  one-cycle completion pulse.
- dmem_rdata_o  out  DWIDTH  read data; valid while dmem_ready_o is high.
- m_valid_o  out  1  request to the adapter (drives its mem_valid).
- m_addr_o  out  AWIDTH  latched address.
- m_wdata_o  out  DWIDTH  latched write data.
- m_wstrb_o  out  4  latched strobes; always 0 for an imem grant.
- m_ready_i  in  1  adapter completion pulse.
- m_rdata_i  in  DWIDTH  adapter read data; valid while m_ready_i is high.

Behaviour:
- All outputs are registered.
- Reset (wb_rst_i=1 at a clock edge) clears every output to 0, sets state to IDLE and sets last_grant to IMEM. It takes effect mid-transaction and abandons any grant; the downstream adapter is reset by the same reset.
- State machine:
  - IDLE: if no request is pending, stay. Otherwise choose the winner:
    - single requester wins;
    - if both request, the port not equal to last_grant wins, so dmem wins the first conflict after reset;
    - latch addr/wdata/wstrb of the winner (imem gives wdata=0, wstrb=0);
    - set grant, last_grant := winner, m_valid_o <= 1, go to BUSY.
  - BUSY: m_valid_o and the m_* fields are held stable. On m_ready_i=1:
    - m_valid_o <= 0;
    - capture m_rdata_i into the granted port's rdata register;
    - pulse the granted port's ready for one cycle;
    - go to RESP.
    - Stall is unbounded; there is no timeout.
  - RESP: the ready pulse is visible this cycle. No arbitration happens in RESP, because the requester still shows valid this cycle and must not be re-granted. Go to IDLE next.
- Latency, best case from request-valid edge to ready: IDLE sample (cycle 0), m_valid_o high (cycle 1). With adapter latency L, m_ready_i arrives at cycle 1+L and the port's ready is high at cycle 2+L.
- Between grants there are at least 2 cycles with m_valid_o=0 (RESP, then IDLE sampling). This meets the adapter's return-to-idle cycle after its ready pulse.
- rdata registers hold their value after the ready pulse until the next completion on the same port. The non-granted port's ready and rdata are unchanged.
- A request arriving while the other port is in BUSY/RESP waits. It is granted at the next IDLE if no conflict, or by round-robin if both are pending.
- m_ready_i while in IDLE or RESP is ignored.
- A requester that keeps valid high after its ready pulse is treated as issuing a new request.
- dmem wstrb is passed through unmodified. Write completion still returns m_rdata_i, which the requester ignores.

Test Plan:
- Reset, then imem_valid=1 with addr=0x0000_0100; adapter returns rdata=0x0000_0013 after 2 cycles -> m_addr_o=0x100 and m_wstrb_o=0; imem_ready_o is a single 1-cycle pulse with imem_rdata_o=0x13; dmem_ready_o stays 0.
- dmem write addr=0x2000_0004, wdata=0xA5A5_5A5A, wstrb=4'b0011 -> m_* carry exactly these values, m_valid_o is held until m_ready_i, and dmem_ready_o pulses once.
- imem and dmem request on the same cycle after reset -> dmem is granted first; imem is granted after RESP+IDLE. A second simultaneous pair then grants imem first (round-robin alternates).
- Adapter stalls 50 cycles in BUSY while imem requests -> m_addr_o/m_wdata_o/m_wstrb_o are stable for all 50 cycles, imem is not granted, and imem is granted right after dmem completes.
- Requester keeps valid high through its ready cycle -> no grant in RESP; a new transaction starts from the following IDLE. m_valid_o is low for at least 2 cycles between transactions.
- Assert wb_rst_i during BUSY -> all outputs are 0 on the next cycle and state is IDLE; a pending dmem request is granted cleanly after reset deasserts.

Source files
------------

// File: rtl/wb_scr_mem_arbiter_if.sv
// Request/response channel shared by the SCR1 memory ports and the Wishbone
// master adapter: valid/ready request with address, write data and strobes.
interface wb_scr_mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              valid;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [3:0]        wstrb;
  logic              ready;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/wb_scr_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone master adapter between the SCR1
// instruction-fetch (imem) and data (dmem) ports; all outputs registered.
//
// state | meaning
// IDLE  | no grant held; arbitrate any pending request
// BUSY  | winner's request presented downstream, waiting for m.ready
// RESP  | ready pulse visible to the winner; no arbitration this cycle
module wb_scr_mem_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  wb_scr_mem_arbiter_if.slave  imem,
  wb_scr_mem_arbiter_if.slave  dmem,
  wb_scr_mem_arbiter_if.master m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_dmem;
  logic              last_dmem;
  logic              any_req;
  logic              win_dmem;
  logic [AWIDTH-1:0] addr_win;
  logic [DWIDTH-1:0] wdata_win;
  logic [3:0]        wstrb_win;
  logic              unused_imem;

  // On a conflict the port that did not win last time takes the grant.
  assign any_req   = imem.valid | dmem.valid;
  assign win_dmem  = dmem.valid & (~imem.valid | ~last_dmem);
  assign addr_win  = win_dmem ? dmem.addr  : imem.addr;
  assign wdata_win = win_dmem ? dmem.wdata : '0;
  assign wstrb_win = win_dmem ? dmem.wstrb : 4'b0000;

  // Fetch port carries no write payload; its wdata/wstrb lines are ignored.
  assign unused_imem = ^{imem.wdata, imem.wstrb};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (m.ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      m.valid    <= 1'b0;
      m.addr     <= '0;
      m.wdata    <= '0;
      m.wstrb    <= 4'b0000;
      imem.ready <= 1'b0;
      imem.rdata <= '0;
      dmem.ready <= 1'b0;
      dmem.rdata <= '0;
      grant_dmem <= 1'b0;
      last_dmem  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            m.valid    <= 1'b1;
            m.addr     <= addr_win;
            m.wdata    <= wdata_win;
            m.wstrb    <= wstrb_win;
            grant_dmem <= win_dmem;
            last_dmem  <= win_dmem;
          end
        end
        BUSY: begin
          if (m.ready) begin
            m.valid <= 1'b0;
            if (grant_dmem) begin
              dmem.ready <= 1'b1;
              dmem.rdata <= m.rdata;
            end else begin
              imem.ready <= 1'b1;
              imem.rdata <= m.rdata;
            end
          end
        end
        RESP: begin
          imem.ready <= 1'b0;
          dmem.ready <= 1'b0;
        end
        default: begin
          m.valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_scr_mem_arbiter.sv
// Self-checking bench for wb_scr_mem_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_wb_scr_mem_arbiter;

  logic clk;
  logic rst;

  wb_scr_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) imem_if ();
  wb_scr_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) dmem_if ();
  wb_scr_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) m_if ();

  wb_scr_mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .imem     (imem_if),
    .dmem     (dmem_if),
    .m        (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction owner + idle gap) -------
  logic        e_mvalid;
  logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
  logic [3:0]  e_mwstrb;
  logic        e_iready, e_dready;
  int          owner = 0;        // 0 none, 1 imem, 2 dmem
  int          rest = 0;         // cycles after a completion before arbitration
  bit          prefer_dmem = 1'b1;
  int          rst_epoch = 0;

  always @(posedge clk) begin
    if (rst) begin
      e_mvalid = 0; e_maddr = 0; e_mwdata = 0; e_mwstrb = 0;
      e_iready = 0; e_irdata = 0; e_dready = 0; e_drdata = 0;
      owner = 0; rest = 0; prefer_dmem = 1'b1;
      rst_epoch++;
    end else begin
      e_iready = 0;
      e_dready = 0;
      if (owner != 0) begin
        if (m_if.ready) begin
          e_mvalid = 0;
          if (owner == 2) begin e_dready = 1; e_drdata = m_if.rdata; end
          else            begin e_iready = 1; e_irdata = m_if.rdata; end
          owner = 0;
          rest  = 1;
        end
      end else if (rest > 0) begin
        rest--;
      end else if (imem_if.valid || dmem_if.valid) begin
        if (dmem_if.valid && (!imem_if.valid || prefer_dmem)) begin
          owner = 2; e_maddr = dmem_if.addr; e_mwdata = dmem_if.wdata; e_mwstrb = dmem_if.wstrb;
          prefer_dmem = 1'b0;
        end else begin
          owner = 1; e_maddr = imem_if.addr; e_mwdata = 0; e_mwstrb = 0;
          prefer_dmem = 1'b1;
        end
        e_mvalid = 1;
      end
    end
  end

  // ---------------- compare process ---------------------------------------
  bit          chk_en = 0;
  logic        p_valid = 0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  int          low_run = 0;
  bit          had_txn = 0;
  int          seen_epoch = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", m_if.valid, e_mvalid);
      chk("m_addr",  m_if.addr,  e_maddr);
      chk("m_wdata", m_if.wdata, e_mwdata);
      chk("m_wstrb", m_if.wstrb, e_mwstrb);
      chk("imem_ready", imem_if.ready, e_iready);
      chk("imem_rdata", imem_if.rdata, e_irdata);
      chk("dmem_ready", dmem_if.ready, e_dready);
      chk("dmem_rdata", dmem_if.rdata, e_drdata);
      if (seen_epoch != rst_epoch) begin
        seen_epoch = rst_epoch;
        had_txn = 0;
      end
      if (m_if.valid && p_valid) begin
        chk("m_fields_stable", {m_if.addr ^ p_addr, m_if.wdata ^ p_wdata, 28'd0, m_if.wstrb ^ p_wstrb} == '0, 1);
      end
      if (m_if.valid && !p_valid) begin
        if (had_txn) chk("m_valid_gap_ge2", low_run >= 2, 1);
        had_txn = 1;
      end
      low_run = m_if.valid ? 0 : low_run + 1;
      p_valid = m_if.valid; p_addr = m_if.addr; p_wdata = m_if.wdata; p_wstrb = m_if.wstrb;
    end
  end

  // ---------------- adapter model ------------------------------------------
  int          lat = 2;
  bit          rand_lat = 0;
  bit          spurious = 0;
  logic [31:0] ad_rdata = 32'h0;
  int          ad_cnt = -1;
  int          ad_epoch = -1;

  always @(negedge clk) begin
    if (ad_epoch != rst_epoch) begin
      ad_epoch = rst_epoch;
      ad_cnt = -1;
      m_if.ready = 1'b0;
    end else if (m_if.ready) begin
      m_if.ready = 1'b0;
    end else if (m_if.valid) begin
      if (ad_cnt < 0) ad_cnt = rand_lat ? int'($urandom_range(0, 5)) : lat;
      if (ad_cnt == 0) begin
        m_if.ready = 1'b1;
        m_if.rdata = rand_lat ? $urandom : ad_rdata;
        ad_cnt = -1;
      end else begin
        ad_cnt--;
      end
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      m_if.ready = 1'b1;
      m_if.rdata = $urandom;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic wait_port(input bit is_d, input bit keep, input int max, output int cyc);
    bit got = 0;
    cyc = 0;
    for (int i = 1; i <= max && !got; i++) begin
      @(negedge clk);
      if (is_d ? dmem_if.ready : imem_if.ready) begin
        got = 1;
        cyc = i;
        if (!keep) begin
          if (is_d) dmem_if.valid = 1'b0;
          else      imem_if.valid = 1'b0;
        end
      end
    end
    chk(is_d ? "wait_dmem_ready" : "wait_imem_ready", got, 1);
  endtask

  task automatic wait_rise(input int max, output int cyc);
    bit got = 0;
    cyc = 0;
    for (int i = 1; i <= max && !got; i++) begin
      @(negedge clk);
      if (m_if.valid) begin got = 1; cyc = i; end
    end
    chk("wait_m_valid", got, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int comps = 0;
  int pwait [2];

  task automatic drive_port(input int p, input bit allow);
    logic v, r;
    v = (p == 1) ? dmem_if.valid : imem_if.valid;
    r = (p == 1) ? dmem_if.ready : imem_if.ready;
    if (v) begin
      if (r) begin
        comps++;
        chk("rand_wait_bound", pwait[p] < 200, 1);
        pwait[p] = 0;
        if (!allow || $urandom_range(0, 3) != 0) begin
          if (p == 1) dmem_if.valid = 1'b0; else imem_if.valid = 1'b0;
        end
      end else begin
        pwait[p]++;
      end
    end else if (allow && $urandom_range(0, 2) == 0) begin
      if (p == 1) begin
        dmem_if.valid = 1'b1; dmem_if.addr = $urandom; dmem_if.wdata = $urandom;
        dmem_if.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end else begin
        imem_if.valid = 1'b1; imem_if.addr = $urandom;
        imem_if.wdata = $urandom; imem_if.wstrb = 4'($urandom);
      end
    end
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    int k, cyc, dpulses;
    bit got, ok;
    rst = 1'b1;
    imem_if.valid = 0; imem_if.addr = 0; imem_if.wdata = 0; imem_if.wstrb = 0;
    dmem_if.valid = 0; dmem_if.addr = 0; dmem_if.wdata = 0; dmem_if.wstrb = 0;
    pwait[0] = 0; pwait[1] = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_imem_ready", imem_if.ready, 0);
    chk("rst_dmem_rdata", dmem_if.rdata, 0);

    // T1: single fetch, adapter latency 2; imem write lines carry junk
    rst = 1'b0;
    lat = 2; ad_rdata = 32'h0000_0013;
    imem_if.valid = 1; imem_if.addr = 32'h0000_0100;
    imem_if.wdata = 32'hDEAD_BEEF; imem_if.wstrb = 4'hF;
    got = 0; k = 0; dpulses = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t1_m_addr", m_if.addr, 32'h100);
        chk("t1_m_wstrb", m_if.wstrb, 0);
        chk("t1_m_wdata", m_if.wdata, 0);
      end
      if (dmem_if.ready) dpulses++;
      if (imem_if.ready) begin
        got = 1; k = i;
        chk("t1_imem_rdata", imem_if.rdata, 32'h13);
        imem_if.valid = 0;
      end
    end
    chk("t1_latency", k, 4);
    @(negedge clk);
    chk("t1_pulse_width", imem_if.ready, 0);
    chk("t1_dmem_quiet", dpulses + int'(dmem_if.ready), 0);

    // T2: dmem write passes fields through
    lat = 3; ad_rdata = 32'h5555_AAAA;
    dmem_if.valid = 1; dmem_if.addr = 32'h2000_0004;
    dmem_if.wdata = 32'hA5A5_5A5A; dmem_if.wstrb = 4'b0011;
    @(negedge clk);
    chk("t2_m_addr", m_if.addr, 32'h2000_0004);
    chk("t2_m_wdata", m_if.wdata, 32'hA5A5_5A5A);
    chk("t2_m_wstrb", m_if.wstrb, 4'b0011);
    wait_port(1, 0, 20, cyc);
    @(negedge clk);
    chk("t2_pulse_width", dmem_if.ready, 0);

    // T3: conflicts after reset; dmem first, then alternation
    do_reset();
    lat = 1; ad_rdata = 32'h0BAD_F00D;
    imem_if.valid = 1; imem_if.addr = 32'h0000_0400;
    dmem_if.valid = 1; dmem_if.addr = 32'h2000_0100; dmem_if.wdata = 32'h1234; dmem_if.wstrb = 4'hF;
    @(negedge clk);
    chk("t3_first_dmem", m_if.addr, 32'h2000_0100);
    wait_port(1, 0, 20, cyc);
    wait_rise(20, cyc);
    chk("t3_imem_after_gap", cyc, 2);
    chk("t3_second_imem", m_if.addr, 32'h0000_0400);
    chk("t3_second_wstrb", m_if.wstrb, 0);
    wait_port(0, 0, 20, cyc);
    dmem_if.valid = 1; dmem_if.addr = 32'h2000_0200; dmem_if.wstrb = 4'h0;
    wait_rise(20, cyc);
    wait_port(1, 0, 20, cyc);
    imem_if.valid = 1; imem_if.addr = 32'h0000_0500;
    dmem_if.valid = 1; dmem_if.addr = 32'h2000_0300;
    wait_rise(20, cyc);
    chk("t3_rr_imem_wins", m_if.addr, 32'h0000_0500);
    wait_port(0, 0, 20, cyc);
    wait_rise(20, cyc);
    chk("t3_rr_dmem_next", m_if.addr, 32'h2000_0300);
    wait_port(1, 0, 20, cyc);

    // T4: 50-cycle stall with imem waiting
    lat = 50; ad_rdata = 32'h7777_0001;
    @(negedge clk);
    dmem_if.valid = 1; dmem_if.addr = 32'h2000_0040; dmem_if.wdata = 32'hCAFE_0001; dmem_if.wstrb = 4'h0;
    wait_rise(20, cyc);
    imem_if.valid = 1; imem_if.addr = 32'h0000_0200;
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_if.addr !== 32'h2000_0040 || m_if.wdata !== 32'hCAFE_0001 ||
          m_if.wstrb !== 4'h0 || m_if.valid !== 1'b1 || imem_if.ready !== 1'b0) ok = 0;
    end
    chk("t4_stall_stable", ok, 1);
    wait_port(1, 0, 10, cyc);
    chk("t4_dmem_done_at", cyc, 1);
    wait_rise(10, cyc);
    chk("t4_imem_next", cyc, 2);
    chk("t4_imem_addr", m_if.addr, 32'h0000_0200);
    lat = 1;
    wait_port(0, 0, 20, cyc);

    // T5: requester holds valid through its ready cycle
    imem_if.valid = 1; imem_if.addr = 32'h0000_0300;
    wait_rise(20, cyc);
    wait_port(0, 1, 20, cyc);
    wait_rise(20, cyc);
    chk("t5_regrant_gap", cyc, 2);
    chk("t5_regrant_addr", m_if.addr, 32'h0000_0300);
    wait_port(0, 0, 20, cyc);

    // T6: reset during BUSY abandons the grant
    lat = 20;
    @(negedge clk);
    dmem_if.valid = 1; dmem_if.addr = 32'h3000_0010; dmem_if.wdata = 32'h0F0F_0F0F; dmem_if.wstrb = 4'h1;
    wait_rise(20, cyc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_m_valid", m_if.valid, 0);
    chk("t6_rst_m_addr", m_if.addr, 0);
    chk("t6_rst_m_wstrb", m_if.wstrb, 0);
    chk("t6_rst_imem_rdata", imem_if.rdata, 0);
    chk("t6_rst_dmem_rdata", dmem_if.rdata, 0);
    lat = 2; ad_rdata = 32'h6666_0006;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_regrant_valid", m_if.valid, 1);
    chk("t6_regrant_addr", m_if.addr, 32'h3000_0010);
    wait_port(1, 0, 20, cyc);
    chk("t6_dmem_rdata", dmem_if.rdata, 32'h6666_0006);

    // Random traffic with random latency and stray adapter ready pulses
    rand_lat = 1; spurious = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      drive_port(0, c < 3500);
      drive_port(1, c < 3500);
    end
    chk("drain_imem_idle", imem_if.valid, 0);
    chk("drain_dmem_idle", dmem_if.valid, 0);
    chk("rand_completions", comps > 200, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
